// File: rtl/i2s_pkg.sv
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S types and sizing. DATA_BIT and SCLK_LRCLK_RATIO
//               defaults apply unless i2s_map.svh has already defined them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_BIT
`define DATA_BIT 24
`endif
`ifndef SCLK_LRCLK_RATIO
`define SCLK_LRCLK_RATIO 64
`endif

package i2s_pkg;

    localparam int DATA_BIT         = `DATA_BIT;
    localparam int SCLK_LRCLK_RATIO = `SCLK_LRCLK_RATIO;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } i2s_tx_state_t;

    typedef logic [DATA_BIT-1:0] i2s_sample_t;

endpackage

`default_nettype wire

// File: rtl/i2s_tx_buffer.sv
// ============================================================================
// Module      : i2s_tx_buffer
// Description : One-pair holding buffer, active-pair load and underrun detect.
//               Optional saturating counter: I2S_TX_UNDERRUN_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_buffer
    import i2s_pkg::*;
#(
    parameter int DATA_BIT = i2s_pkg::DATA_BIT
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                i_clk_12_288,
    input  logic                i_reset_n,
    input  logic                i_load,
    input  logic                i_valid,
    input  logic [DATA_BIT-1:0] i_left,
    input  logic [DATA_BIT-1:0] i_right,
    output logic                o_ready,
    output logic [DATA_BIT-1:0] o_active_left,
    output logic [DATA_BIT-1:0] o_active_right,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [CNT_W-1:0]    o_underrun_count,
`endif
    output logic                o_underrun
);

    logic [DATA_BIT-1:0] hold_left_q,   hold_left_d;
    logic [DATA_BIT-1:0] hold_right_q,  hold_right_d;
    logic [DATA_BIT-1:0] act_left_q,    act_left_d;
    logic [DATA_BIT-1:0] act_right_q,   act_right_d;
    logic                hold_full_q,   hold_full_d;
    logic                ready_q;
    logic                underrun_q,    underrun_d;
    logic                accept;

    // Load looks at the pre-cycle flag, so a same-cycle accept is kept for the next frame.
    always_comb begin
        accept       = i_valid & ~hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        act_left_d   = act_left_q;
        act_right_d  = act_right_q;
        hold_full_d  = hold_full_q;
        underrun_d   = 1'b0;
        if (i_load) begin
            if (hold_full_q) begin
                act_left_d  = hold_left_q;
                act_right_d = hold_right_q;
                hold_full_d = 1'b0;
            end else begin
                act_left_d  = '0;
                act_right_d = '0;
                underrun_d  = 1'b1;
            end
        end
        if (accept) begin
            hold_left_d  = i_left;
            hold_right_d = i_right;
            hold_full_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_left_q  <= '0;
            hold_right_q <= '0;
            act_left_q   <= '0;
            act_right_q  <= '0;
            hold_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            underrun_q   <= 1'b0;
        end else begin
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            act_left_q   <= act_left_d;
            act_right_q  <= act_right_d;
            hold_full_q  <= hold_full_d;
            ready_q      <= ~hold_full_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (underrun_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_underrun_count = cnt_q;
`endif

    assign o_ready        = ready_q;
    assign o_active_left  = act_left_q;
    assign o_active_right = act_right_q;
    assign o_underrun     = underrun_q;

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module      : i2s_tx
// Description : Stereo I2S transmitter: frame FSM and MSB-first serialiser.
//               Optional underrun counter port: I2S_TX_UNDERRUN_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_BIT = i2s_pkg::DATA_BIT
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                        i_clk_12_288,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_sclk,
    input  logic                        i_start,
    input  logic                        i_finish,
    input  logic [$clog2(DATA_BIT)-1:0] i_count,
    input  logic                        i_count_valid,
    input  logic                        i_count_lrclk,
    input  logic [DATA_BIT-1:0]         i_left,
    input  logic [DATA_BIT-1:0]         i_right,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_sd,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [CNT_W-1:0]            o_underrun_count,
`endif
    output logic                        o_underrun
);

    i2s_tx_state_t       state_q, state_d;
    logic                sd_q, sd_d;
    logic                load;
    logic                bit_sel;
    logic [DATA_BIT-1:0] act_left;
    logic [DATA_BIT-1:0] act_right;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_enable)  state_d = ARMED;
            ARMED:   if (!i_enable) state_d = IDLE;
                     else if (i_start) state_d = RUN;
            RUN:     if (!i_enable) state_d = DRAIN;
            DRAIN:   if (i_enable)  state_d = RUN;
                     else if (i_finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A start seen while ARMED but already disabled does not consume the held pair.
    assign load = i_start & ((state_q == RUN) | ((state_q == ARMED) & i_enable));

    always_comb begin
        bit_sel = 1'b0;
        if (((state_q == RUN) || (state_q == DRAIN)) && i_count_valid) begin
            bit_sel = i_count_lrclk ? act_left[i_count] : act_right[i_count];
        end
        sd_d = sd_q;
        if ((state_d != RUN) && (state_d != DRAIN)) begin
            sd_d = 1'b0;
        end else if (i_sclk) begin
            sd_d = bit_sel;
        end
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sd_q    <= sd_d;
        end
    end

    i2s_tx_buffer #(
        .DATA_BIT         (DATA_BIT)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .CNT_W            (CNT_W)
`endif
    ) u_buffer (
        .i_clk_12_288     (i_clk_12_288),
        .i_reset_n        (i_reset_n),
        .i_load           (load),
        .i_valid          (i_valid),
        .i_left           (i_left),
        .i_right          (i_right),
        .o_ready          (o_ready),
        .o_active_left    (act_left),
        .o_active_right   (act_right),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .o_underrun_count (o_underrun_count),
`endif
        .o_underrun       (o_underrun)
    );

    assign o_sd = sd_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// Module      : tb_i2s_tx
// Description : Directed self-checking bench for i2s_tx (24-bit, 64 SCLK/frame,
//               4 MCLK per SCLK).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx;

    localparam int DB = 24;
    localparam int CW = $clog2(DB);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_enable, i_sclk, i_start, i_finish;
    logic [CW-1:0] i_count;
    logic          i_count_valid, i_count_lrclk;
    logic [DB-1:0] i_left, i_right;
    logic          i_valid;
    logic          o_ready, o_sd, o_underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [3:0]    o_underrun_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int pk       = 0;
    int fr       = 0;
    bit hold_valid = 1'b0;

    always #41 clk = ~clk;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    i2s_tx #(.CNT_W(4)) dut (
        .i_clk_12_288     (clk),
        .i_reset_n        (rst_n),
        .i_enable         (i_enable),
        .i_sclk           (i_sclk),
        .i_start          (i_start),
        .i_finish         (i_finish),
        .i_count          (i_count),
        .i_count_valid    (i_count_valid),
        .i_count_lrclk    (i_count_lrclk),
        .i_left           (i_left),
        .i_right          (i_right),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_sd             (o_sd),
        .o_underrun_count (o_underrun_count),
        .o_underrun       (o_underrun)
    );
`else
    i2s_tx dut (
        .i_clk_12_288     (clk),
        .i_reset_n        (rst_n),
        .i_enable         (i_enable),
        .i_sclk           (i_sclk),
        .i_start          (i_start),
        .i_finish         (i_finish),
        .i_count          (i_count),
        .i_count_valid    (i_count_valid),
        .i_count_lrclk    (i_count_lrclk),
        .i_left           (i_left),
        .i_right          (i_right),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_sd             (o_sd),
        .o_underrun       (o_underrun)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] pl(input int k);
        return 24'hC30000 + k[23:0];
    endfunction

    function automatic logic [DB-1:0] pr(input int k);
        return 24'h3C0000 + k[23:0];
    endfunction

    task automatic idle(input int n);
        i_sclk = 1'b0; i_start = 1'b0; i_finish = 1'b0;
        i_count = '0; i_count_valid = 1'b0; i_count_lrclk = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_sd", o_sd, 0);
        end
    endtask

    // One 256-cycle frame; o_sd checked once per slot, underrun at the load edge.
    task automatic run_frame(input logic [DB-1:0] eL, input logic [DB-1:0] eR, input bit eur,
                             input int drop_pos, input int push_pos,
                             input logic [DB-1:0] pL, input logic [DB-1:0] pR,
                             input int rdy_mid, input int exp_acc);
        int  acc0;
        bit  acc_now;
        int  slot, ph, s;
        logic e;
        acc0 = acc_cnt;
        fr++;
        for (int p = 0; p < 256; p++) begin
            slot = p / 4;
            ph   = p % 4;
            s    = slot % 32;
            i_sclk        = (ph >= 2);
            i_start       = (p == 0);
            i_finish      = (p == 255);
            i_count_lrclk = (slot < 32);
            i_count_valid = (s < 24);
            i_count       = (s < 24) ? CW'(23 - s) : '0;
            if (p == drop_pos) i_enable = 1'b0;
            if (p == push_pos) begin
                i_left = pL; i_right = pR; i_valid = 1'b1;
            end
            acc_now = i_valid && o_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                acc_cnt++;
                if (hold_valid) begin
                    pk++;
                    i_left  = pl(pk);
                    i_right = pr(pk);
                end
            end
            if (!hold_valid && p == push_pos) i_valid = 1'b0;
            if (p == 0) chk($sformatf("underrun f%0d", fr), o_underrun, eur);
            if (p == 1) chk($sformatf("underrun_off f%0d", fr), o_underrun, 0);
            if (p == 128 && rdy_mid >= 0) chk($sformatf("ready_mid f%0d", fr), o_ready, rdy_mid);
            if (ph == 3) begin
                e = 1'b0;
                if (s < 24) e = (slot < 32) ? eL[23 - s] : eR[23 - s];
                chk($sformatf("sd f%0d slot%0d", fr, slot), o_sd, e);
            end
        end
        i_start = 1'b0; i_finish = 1'b0; i_sclk = 1'b0;
        if (exp_acc >= 0) chk($sformatf("accepts f%0d", fr), acc_cnt - acc0, exp_acc);
    endtask

    initial begin
        rst_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0;
        i_left = '0; i_right = '0;
        i_sclk = 1'b0; i_start = 1'b0; i_finish = 1'b0;
        i_count = '0; i_count_valid = 1'b0; i_count_lrclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sd", o_sd, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_underrun", o_underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("rst_count", o_underrun_count, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Enable and pre-load the first pair.
        i_enable = 1'b1;
        i_left = 24'h800001; i_right = 24'h7FFFFE; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("ready_after_push", o_ready, 0);
        idle(3);

        // Frame 1: pre-loaded pair, no underrun.
        run_frame(24'h800001, 24'h7FFFFE, 1'b0, -1, -1, '0, '0, 1, -1);
        // Frame 2: nothing pushed.
        run_frame('0, '0, 1'b1, -1, -1, '0, '0, 1, -1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("count_after_f2", o_underrun_count, 1);
`endif
        // Frame 3: push coincides with start on an empty buffer.
        run_frame('0, '0, 1'b1, -1, 0, 24'h123456, 24'hABCDEF, 0, 1);
        // Frame 4: that pair goes out; continuous valid begins mid-frame.
        hold_valid = 1'b1;
        pk = 1;
        run_frame(24'h123456, 24'hABCDEF, 1'b0, -1, 100, pl(1), pr(1), -1, 1);
        for (int j = 1; j <= 8; j++) begin
            run_frame(pl(j), pr(j), 1'b0, -1, -1, '0, '0, 0, 1);
        end
        hold_valid = 1'b0;
        i_valid = 1'b0;
        // Frame 13: last queued pair; push the next one mid-frame.
        run_frame(pl(9), pr(9), 1'b0, -1, 50, 24'hF0F0F0, 24'h0F0F0F, 0, 1);
        // Frame 14: enable drops in the left slot, the frame still completes.
        run_frame(24'hF0F0F0, 24'h0F0F0F, 1'b0, 40, -1, '0, '0, 1, 0);
        // Frame 15: disabled, silent, no underrun.
        run_frame('0, '0, 1'b0, -1, -1, '0, '0, 1, 0);

        // Back-to-back underruns.
        i_enable = 1'b1;
        idle(4);
        for (int j = 0; j < 19; j++) begin
            run_frame('0, '0, 1'b1, -1, -1, '0, '0, 1, 0);
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("count_saturated", o_underrun_count, 15);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_sd", o_sd, 0);
        chk("rst2_ready", o_ready, 1);
        chk("rst2_underrun", o_underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("rst2_count", o_underrun_count, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter for the audio path, directly downstream of `i2s_clk`. Accepts one left/right PCM sample pair per frame over a valid/ready handshake and holds it in a one-pair buffer. Serialises the pair onto `o_sd`, MSB first, using the bit index, channel and frame ticks produced by `i2s_clk`. Signals underruns when no sample pair is ready at a frame boundary.

## Interface
Parameters:
- `DATA_BIT`, default `` `DATA_BIT `` (i2s_map.svh): sample width per channel.
- `CNT_W`, default 16: underrun counter width (only with `I2S_TX_UNDERRUN_CNT_EN`).

Ports:
- `i_clk_12_288`  in  1  system/MCLK clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  transmit enable, level.
- `i_sclk`  in  1  SCLK from `i2s_clk`.
- `i_start`  in  1  one-cycle frame-start tick.
- `i_finish`  in  1  one-cycle frame-end tick.
- `i_count`  in  $clog2(DATA_BIT)  bit index, DATA_BIT-1 down to 0.
- `i_count_valid`  in  1  current SCLK slot carries payload.
- `i_count_lrclk`  in  1  1 = left slot, 0 = right slot.
- `i_left`, `i_right`  in  DATA_BIT each  sample pair, two's complement.
- `i_valid`  in  1  sample pair valid.
- `o_ready`  out  1  holding buffer empty.
- `o_sd`  out  1  serial data.
- `o_underrun`  out  1  one-cycle underrun pulse.
- `o_underrun_count`  out  CNT_W  saturating underrun count (macro only).

## Operation
- The holding buffer stores one stereo pair and a `hold_full` flag.
  - `o_ready = ~hold_full`, driven from a register only.
  - A pair is accepted when `i_valid & o_ready`.
- The active register stores the pair currently being shifted out.
- State machine:
  - IDLE → ARMED when `i_enable` = 1.
  - ARMED → RUN on `i_start`.
  - RUN → DRAIN when `i_enable` falls.
  - DRAIN → IDLE on `i_finish`.
  - DRAIN → RUN if `i_enable` reasserts before `i_finish`.
  - ARMED → IDLE if `i_enable` falls.
- Frame load, on `i_start` in ARMED or RUN:
  - If `hold_full`: active ← holding and `hold_full` clears.
  - Otherwise: active ← 0 and `o_underrun` pulses.
- Start and accept in the same cycle:
  - The load uses the pre-cycle `hold_full`.
  - The new pair lands in the holding buffer for the next frame.
  - This case counts as an underrun if the buffer was empty.
- Bit select: `active_left[i_count]` when `i_count_lrclk` = 1, else `active_right[i_count]`. The result is 0 when `i_count_valid` = 0 or state ∉ {RUN, DRAIN}.
- In IDLE and ARMED, `o_sd` = 0 and no underruns are reported. The holding buffer still accepts one pair, so a pair can be pre-loaded before enable.

## Timing
- Reset values:
  - `o_sd` = 0, `o_ready` = 1, `o_underrun` = 0, `o_underrun_count` = 0.
  - State IDLE; holding and active registers cleared.
- `o_sd` is registered and updates only on clock edges where `i_sclk` = 1, so transitions align to the SCLK falling edge. Data is stable across the SCLK rising edge.
- Frame format is left-justified to `i_count`; no extra I2S one-bit delay is inserted.
- Handshake to `hold_full`: 1 cycle, so `o_ready` drops the cycle after acceptance.
- Accepted pair to first `o_sd` bit: the next `i_start` plus 1 cycle.
- `i_enable` deassert mid-frame: the current frame completes. `o_sd` = 0 from the cycle after `i_finish`.
- Async reset mid-frame: all state clears immediately; `o_sd` = 0.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - Adds port `o_underrun_count`.
  - The counter increments on each `o_underrun` pulse and saturates at 2^CNT_W−1.
  - It clears only on reset.
- Undefined: the port and counter are absent; only the `o_underrun` pulse exists.

## Structure
- `DATA_BIT` and `SCLK_LRCLK_RATIO` come from `i2s_map.svh`.
- The state enum `i2s_tx_state_t` (IDLE, ARMED, RUN, DRAIN) and the `i2s_sample_t` (logic [DATA_BIT-1:0]) typedefs go in shared package `i2s_pkg`.
- One sub-module: `i2s_tx_buffer` (holding register, handshake, active-register load, underrun detect). The top level contains the FSM and bit serialiser.

## Test plan
- Enable; push L=0x800001, R=0x7FFFFE before the first `i_start` → frame 1 `o_sd` shows 1,0…0,1 in the left slot and 0,1…1,0 in the right slot, MSB first; `o_underrun` stays 0.
- No pair pushed for frame 2 → `o_underrun` pulses 1 cycle at `i_start`; `o_sd` = 0 for the whole frame; count = 1.
- `i_valid` held high continuously → exactly one pair accepted per frame; `o_ready` low between frame loads; no underruns over 8 frames.
- Pair accepted in the same cycle as `i_start` with the buffer empty → underrun for that frame; the pair transmits in the following frame.
- Drop `i_enable` mid left slot → the remaining bits of the frame transmit; `o_sd` = 0 after `i_finish`; state IDLE.
- 2^CNT_W+3 consecutive underruns (CNT_W=4 in the bench) → `o_underrun_count` holds at 15; reset returns it to 0.
